// File: rtl/inst_fetch_if.sv
// Bundles the fetch-stage control inputs, instruction-memory port and decode-facing outputs.
// Latency: none; this is wiring only.
// Backpressure: stall/redirect arrive from downstream; the master side owns the outputs.
interface inst_fetch_if #(
   parameter int INST_MEM_WIDTH = 2
);
   logic                      start;
   logic                      stall;
   logic                      redirect;
   logic [INST_MEM_WIDTH-1:0] target;
   logic [INST_MEM_WIDTH-1:0] imem_addr;
   logic [31:0]               imem_rdata;
   logic [31:0]               inst;
   logic [INST_MEM_WIDTH-1:0] pc;
   logic [INST_MEM_WIDTH-1:0] pc1;
   logic                      distinct;
   logic                      inst_enable;
   logic                      halted;

   // Fetch stage side.
   modport master (
      input  start, stall, redirect, target, imem_rdata,
      output imem_addr, inst, pc, pc1, distinct, inst_enable, halted
   );

   // Decode / memory / control side.
   modport slave (
      output start, stall, redirect, target, imem_rdata,
      input  imem_addr, inst, pc, pc1, distinct, inst_enable, halted
   );
endinterface

// File: rtl/inst_fetch.sv
// Instruction fetch: owns the PC, drives a 1-cycle synchronous instruction memory, feeds decode.
// Latency: an issued address is presented to decode one cycle later.
// Backpressure: stall re-reads the held address; redirect drops the in-flight word and refetches at target.
module inst_fetch #(
   parameter int          INST_MEM_WIDTH = 2,
   parameter logic [31:0] HALT_INST      = 32'hFFFF_FFFF
) (
   input  logic         CLK,
   input  logic         reset,
   inst_fetch_if.master bus
);
   typedef logic [INST_MEM_WIDTH-1:0] addr_t;
   typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;

   localparam addr_t ONE = addr_t'(1);

   state_t state;
   addr_t  fetch_pc;
   addr_t  out_pc;
   logic   out_valid;
   logic   distinct_q;
   logic   enable;
   logic   halt_hit;
   addr_t  addr_mux;

   // Decode-facing outputs: the memory word is only exposed while it belongs to a live fetch.
   assign bus.inst        = out_valid ? bus.imem_rdata : 32'd0;
   assign bus.pc          = out_pc;
   assign bus.pc1         = out_pc + ONE;
   assign bus.distinct    = distinct_q;
   assign bus.halted      = (state == HALT);
   assign enable          = (state == RUN) & out_valid & ~bus.stall & ~bus.redirect;
   assign bus.inst_enable = enable;
   assign bus.imem_addr   = addr_mux;

   // The halt word is still handed to decode; fetch stops right after it.
   assign halt_hit = enable && (bus.inst == HALT_INST);

   // Memory address select: redirect beats stall beats advance; stall and halt re-read out_pc
   // so the memory output stays stable on the next cycle.
   always_comb begin
      addr_mux = fetch_pc;
      case (state)
         IDLE: addr_mux = fetch_pc;
         RUN: begin
            if (bus.redirect)
               addr_mux = bus.target;
            else if (bus.stall || halt_hit)
               addr_mux = out_pc;
            else
               addr_mux = fetch_pc;
         end
         HALT:    addr_mux = out_pc;
         default: addr_mux = fetch_pc;
      endcase
   end

   // PC / state machine; reset discards any in-flight read by clearing out_valid.
   always_ff @(posedge CLK or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         fetch_pc   <= '0;
         out_pc     <= '0;
         out_valid  <= 1'b0;
         distinct_q <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.start) begin
                  out_pc    <= fetch_pc;
                  fetch_pc  <= fetch_pc + ONE;
                  out_valid <= 1'b1;
                  state     <= RUN;
               end
            end
            RUN: begin
               if (bus.redirect) begin
                  out_pc     <= bus.target;
                  fetch_pc   <= bus.target + ONE;
                  out_valid  <= 1'b1;
                  distinct_q <= ~distinct_q;
               end else if (bus.stall) begin
                  // hold everything
               end else if (halt_hit) begin
                  out_valid <= 1'b0;
                  state     <= HALT;
               end else begin
                  out_pc   <= fetch_pc;
                  fetch_pc <= fetch_pc + ONE;
               end
            end
            HALT: begin
               // only reset leaves HALT
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch with a 4-word synchronous instruction memory.
// Latency: checks outputs 1-2 time units after each rising edge, after inputs are applied.
// Backpressure: exercises stall, redirect, stall+redirect, halt and asynchronous reset.
module tb_inst_fetch;
   localparam int W = 2;
   localparam logic [31:0] IA   = 32'hA0A0_0001;
   localparam logic [31:0] IB   = 32'hB0B0_0002;
   localparam logic [31:0] IC   = 32'hC0C0_0003;
   localparam logic [31:0] ID   = 32'hD0D0_0004;
   localparam logic [31:0] HLT  = 32'hFFFF_FFFF;

   logic CLK = 1'b0;
   logic reset = 1'b0;
   logic [31:0] mem [0:3];
   int checks = 0;
   int failures = 0;

   inst_fetch_if #(.INST_MEM_WIDTH(W)) bus();

   inst_fetch #(.INST_MEM_WIDTH(W), .HALT_INST(HLT)) dut (
      .CLK   (CLK),
      .reset (reset),
      .bus   (bus)
   );

   // Clock generation.
   always #5 CLK = ~CLK;

   // Synchronous-read instruction memory, 1-cycle latency.
   always @(posedge CLK) bus.imem_rdata <= mem[bus.imem_addr];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic look(input string tag, input logic en, input logic [31:0] i,
                       input logic [1:0] p, input logic d, input logic h);
      logic [1:0] p1;
      p1 = p + 2'd1;
      chk({tag, ".en"},   32'(bus.inst_enable), 32'(en));
      chk({tag, ".inst"}, bus.inst, i);
      chk({tag, ".pc"},   32'(bus.pc), 32'(p));
      chk({tag, ".pc1"},  32'(bus.pc1), 32'(p1));
      chk({tag, ".dist"}, 32'(bus.distinct), 32'(d));
      chk({tag, ".halt"}, 32'(bus.halted), 32'(h));
   endtask

   task automatic cyc();
      @(posedge CLK);
      #1;
   endtask

   initial begin
      mem[0] = IA; mem[1] = IB; mem[2] = IC; mem[3] = ID;
      bus.start = 1'b0; bus.stall = 1'b0; bus.redirect = 1'b0; bus.target = '0;

      // Reset state
      #12;
      look("rst", 0, 32'd0, 2'd0, 0, 0);
      chk("rst.addr", 32'(bus.imem_addr), 32'd0);
      reset = 1'b1;

      // Start and sequential fetch with wrap
      cyc(); bus.start = 1'b1; #1;
      look("idle", 0, 32'd0, 2'd0, 0, 0);
      chk("idle.addr", 32'(bus.imem_addr), 32'd0);
      cyc(); bus.start = 1'b0; #1; look("f0", 1, IA, 2'd0, 0, 0);
      cyc(); #1; look("f1", 1, IB, 2'd1, 0, 0);
      cyc(); #1; look("f2", 1, IC, 2'd2, 0, 0);
      cyc(); #1; look("f3", 1, ID, 2'd3, 0, 0);
      cyc(); #1; look("f4", 1, IA, 2'd0, 0, 0);

      // Stall for 3 cycles at pc=1
      cyc(); bus.stall = 1'b1; #1;
      look("st0", 0, IB, 2'd1, 0, 0);
      chk("st0.addr", 32'(bus.imem_addr), 32'd1);
      cyc(); #1; look("st1", 0, IB, 2'd1, 0, 0);
      cyc(); #1; look("st2", 0, IB, 2'd1, 0, 0);
      cyc(); bus.stall = 1'b0; #1; look("strel", 1, IB, 2'd1, 0, 0);
      cyc(); #1; look("stnx", 1, IC, 2'd2, 0, 0);
      cyc(); #1; look("a3", 1, ID, 2'd3, 0, 0);
      cyc(); #1; look("a0", 1, IA, 2'd0, 0, 0);

      // Redirect to 3 while pc=1
      cyc(); bus.redirect = 1'b1; bus.target = 2'd3; #1;
      look("rd0", 0, IB, 2'd1, 0, 0);
      chk("rd0.addr", 32'(bus.imem_addr), 32'd3);
      cyc(); bus.redirect = 1'b0; #1; look("rd1", 1, ID, 2'd3, 1, 0);
      cyc(); #1; look("rd2", 1, IA, 2'd0, 1, 0);

      // Redirect and stall together: redirect wins, distinct toggles back
      cyc(); bus.redirect = 1'b1; bus.stall = 1'b1; bus.target = 2'd2; #1;
      look("rs0", 0, IB, 2'd1, 1, 0);
      chk("rs0.addr", 32'(bus.imem_addr), 32'd2);
      cyc(); bus.redirect = 1'b0; bus.stall = 1'b0; #1; look("rs1", 1, IC, 2'd2, 0, 0);
      mem[2] = HLT;
      cyc(); #1; look("rs2", 1, ID, 2'd3, 0, 0);

      // Halt: redirect to 1, then the halt word arrives at pc=2
      cyc(); bus.redirect = 1'b1; bus.target = 2'd1; #1;
      look("hrd", 0, IA, 2'd0, 0, 0);
      cyc(); bus.redirect = 1'b0; #1; look("h1", 1, IB, 2'd1, 1, 0);
      cyc(); #1; look("h2", 1, HLT, 2'd2, 1, 0);
      cyc(); #1; look("h3", 0, 32'd0, 2'd2, 1, 1);
      bus.stall = 1'b1; bus.redirect = 1'b1; bus.target = 2'd0; bus.start = 1'b1;
      cyc(); #1; look("h4", 0, 32'd0, 2'd2, 1, 1);
      cyc(); #1; look("h5", 0, 32'd0, 2'd2, 1, 1);
      bus.stall = 1'b0; bus.redirect = 1'b0; bus.start = 1'b0;

      // Reset leaves HALT (asserted between edges)
      #2; reset = 1'b0; #1;
      look("hrst", 0, 32'd0, 2'd0, 0, 0);
      mem[2] = IC;
      #2; reset = 1'b1;

      // Restart, run to pc=2, then asynchronous reset mid-run
      cyc(); bus.start = 1'b1;
      cyc(); bus.start = 1'b0; #1; look("r0", 1, IA, 2'd0, 0, 0);
      cyc(); #1; look("r1", 1, IB, 2'd1, 0, 0);
      cyc(); #1; look("r2", 1, IC, 2'd2, 0, 0);
      #2; reset = 1'b0; #1;
      look("ar", 0, 32'd0, 2'd0, 0, 0);
      chk("ar.addr", 32'(bus.imem_addr), 32'd0);
      #2; reset = 1'b1;

      // Back in IDLE until start
      cyc(); #1;
      look("idl2", 0, 32'd0, 2'd0, 0, 0);
      cyc(); #1;
      look("idl3", 0, 32'd0, 2'd0, 0, 0);
      chk("idl3.addr", 32'(bus.imem_addr), 32'd0);
      bus.start = 1'b1;
      cyc(); bus.start = 1'b0; #1; look("rs_f0", 1, IA, 2'd0, 0, 0);
      cyc(); #1; look("rs_f1", 1, IB, 2'd1, 0, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/inst_fetch.md
Name: inst_fetch

Overview:
Instruction-fetch stage directly upstream of instruction decode. It owns the program counter and drives a synchronous-read instruction memory with 1-cycle read latency. Toward decode it presents inst/pc/pc1/distinct and qualifies each with inst_enable. It honours pipeline stall, branch/jump redirect, start after program load, and stop on a halt instruction.

Parameters:
INST_MEM_WIDTH, 2, instruction-memory address width; all PCs are this wide and wrap modulo 2^INST_MEM_WIDTH.
HALT_INST, 32'hFFFF_FFFF, instruction word that stops fetch.

Ports:
CLK  in  1  clock; all state updates on posedge.
reset  in  1  asynchronous, active-low reset (0 = reset asserted).
start  in  1  leave IDLE and begin fetching at address 0.
stall  in  1  hold the current instruction; decode must not latch.
redirect  in  1  branch/jump taken; resume fetch at target.
target  in  INST_MEM_WIDTH  redirect address.
imem_addr  out  INST_MEM_WIDTH  read address to instruction memory.
imem_rdata  in  32  data for the address issued in the previous cycle.
inst  out  32  instruction to decode; 0 when out_valid=0.
pc  out  INST_MEM_WIDTH  address of inst.
pc1  out  INST_MEM_WIDTH  pc+1, wrapping.
distinct  out  1  path epoch bit; toggles on every accepted redirect.
inst_enable  out  1  inst/pc/pc1/distinct are valid this cycle; decode latches them.
halted  out  1  fetch stopped on HALT_INST.

Behaviour:
- Registers: fetch_pc (next address to issue), out_pc, out_valid, distinct, state ∈ {IDLE, RUN, HALT}.
- Reset (asynchronous, reset=0): fetch_pc=0, out_pc=0, out_valid=0, distinct=0, state=IDLE. Outputs read inst=0, pc=0, pc1=1, inst_enable=0, halted=0, imem_addr=0. Reset mid-run discards any in-flight read. First issue after release goes to address 0.
- Combinational outputs: inst = out_valid ? imem_rdata : 0. pc = out_pc. pc1 = out_pc+1. inst_enable = (state==RUN) & out_valid & ~stall & ~redirect.
- IDLE:
  - imem_addr = fetch_pc; nothing else changes.
  - When start=1: issue fetch_pc, out_pc<=fetch_pc, fetch_pc<=fetch_pc+1, out_valid<=1, go to RUN. The first inst_enable occurs the next cycle (1-cycle latency).
  - stall, redirect and target are ignored in IDLE.
- RUN, priority order redirect > stall > advance:
  - Redirect: imem_addr=target, out_pc<=target, fetch_pc<=target+1, out_valid<=1, distinct<=~distinct. inst_enable=0 this cycle, so the wrong-path instruction is dropped. The instruction at target is presented the next cycle.
  - Stall: imem_addr=out_pc, which re-reads the held address so imem_rdata stays stable next cycle. fetch_pc, out_pc and out_valid hold. inst_enable=0.
  - Advance: imem_addr=fetch_pc, out_pc<=fetch_pc, fetch_pc<=fetch_pc+1.
  - Halt: if inst_enable=1 and inst==HALT_INST, the halt word is still delivered to decode that cycle (inst_enable=1). Next state is HALT, out_valid<=0, and imem_addr=out_pc.
- HALT: halted=1 and inst_enable=0. No register changes; start, stall and redirect are ignored. Only reset exits HALT.
- start is ignored outside IDLE.
- PC arithmetic: all +1 operations wrap modulo 2^INST_MEM_WIDTH; with width 2, 3+1=0.

Test Plan:
- Reset/start: hold reset=0, check inst_enable=0, pc=0, pc1=1, halted=0. Release, pulse start at cycle 0 with mem={A,B,C,D} -> inst_enable=1 at cycles 1..4 with (inst,pc) = (A,0),(B,1),(C,2),(D,3), then (A,0) after wrap; pc1 reads 1,2,3,0.
- Stall: assert stall for 3 cycles while pc=1 -> inst_enable=0 for those 3 cycles with inst=B, pc=1 held. On release the next cycle gives inst_enable=1 with B/pc=1, then C/pc=2. No instruction is skipped or duplicated.
- Redirect: redirect=1, target=3 while pc=1 -> that cycle inst_enable=0. Next cycle D/pc=3 with distinct=1. A second redirect toggles distinct back to 0. Redirect and stall in the same cycle -> the redirect takes effect.
- Halt: mem[2]=32'hFFFF_FFFF -> the halt word is delivered at pc=2 with inst_enable=1. From the next cycle halted=1 and inst_enable=0 permanently; stall, redirect and start have no effect.
- Async reset mid-run: drive reset=0 between clock edges while pc=2 -> outputs return to their reset values immediately without a clock. After release, state=IDLE, and start restarts fetch at address 0.
